// File: rtl/divsqrtrecfn_issuer_if.sv
// Bundle of request, divider and response signals around the div/sqrt issuer.
// The slave modport is the issuer's view; master is the surrounding pipeline/divider view.
interface divsqrtrecfn_issuer_if #(
  parameter int expWidth = 8,
  parameter int sigWidth = 24,
  parameter int tagWidth = 4
);
  localparam int recW = expWidth + sigWidth + 1;

  logic                req_valid;
  logic                req_ready;
  logic                req_sqrtOp;
  logic [recW-1:0]     req_a;
  logic [recW-1:0]     req_b;
  logic [2:0]          req_roundingMode;
  logic [tagWidth-1:0] req_tag;

  logic                div_inReady;
  logic                div_inValid;
  logic                div_sqrtOp;
  logic [recW-1:0]     div_a;
  logic [recW-1:0]     div_b;
  logic [2:0]          div_roundingMode;
  logic                div_outValid;
  logic                div_sqrtOpOut;
  logic [recW-1:0]     div_out;
  logic [4:0]          div_exceptionFlags;

  logic                resp_valid;
  logic                resp_ready;
  logic                resp_sqrtOp;
  logic [recW-1:0]     resp_out;
  logic [4:0]          resp_exceptionFlags;
  logic [tagWidth-1:0] resp_tag;

  logic                protoErr;

  modport slave (
    input  req_valid, req_sqrtOp, req_a, req_b, req_roundingMode, req_tag,
    output req_ready,
    input  div_inReady, div_outValid, div_sqrtOpOut, div_out, div_exceptionFlags,
    output div_inValid, div_sqrtOp, div_a, div_b, div_roundingMode,
    input  resp_ready,
    output resp_valid, resp_sqrtOp, resp_out, resp_exceptionFlags, resp_tag,
    output protoErr
  );

  modport master (
    output req_valid, req_sqrtOp, req_a, req_b, req_roundingMode, req_tag,
    input  req_ready,
    output div_inReady, div_outValid, div_sqrtOpOut, div_out, div_exceptionFlags,
    input  div_inValid, div_sqrtOp, div_a, div_b, div_roundingMode,
    output resp_ready,
    input  resp_valid, resp_sqrtOp, resp_out, resp_exceptionFlags, resp_tag,
    input  protoErr
  );
endinterface

// File: rtl/divsqrtrecfn_issuer.sv
// Front-end for the iterative divSqrtRecFN unit: accepts tagged requests, issues
// one operation at a time, and returns results through a response FIFO. A FIFO
// slot is reserved before issue so the un-backpressured result pulse is never lost.
module divsqrtrecfn_issuer #(
  parameter int expWidth  = 8,
  parameter int sigWidth  = 24,
  parameter int tagWidth  = 4,
  parameter int respDepth = 2
) (
  input logic                 clock,
  input logic                 nReset,
  divsqrtrecfn_issuer_if.slave io
);
  localparam int recW   = expWidth + sigWidth + 1;
  localparam int cntW   = $clog2(respDepth + 1);
  localparam int ptrW   = (respDepth > 1) ? $clog2(respDepth) : 1;
  localparam int entryW = 1 + recW + 5 + tagWidth;

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

  state_t              state;
  logic [tagWidth-1:0] heldTag;
  logic [cntW-1:0]     count;
  logic [ptrW-1:0]     wrPtr;
  logic [ptrW-1:0]     rdPtr;
  logic [entryW-1:0]   mem [respDepth];

  logic busyDone;
  logic accept;
  logic push;
  logic pop;
  logic reqReady;

  function automatic logic [ptrW-1:0] nextPtr(input logic [ptrW-1:0] p);
    return (p == ptrW'(respDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign busyDone = (state == BUSY) && io.div_outValid;
  assign push     = busyDone;
  assign pop      = io.resp_valid && io.resp_ready;
  assign accept   = io.req_valid && reqReady;

  // Credit check: the in-flight op (or the one completing now) must already own a slot,
  // and the new request needs one more; pops in this cycle are not counted.
  always_comb begin
    reqReady = 1'b0;
    if (state == IDLE)
      reqReady = ({1'b0, count} < (cntW + 1)'(respDepth));
    else if (busyDone)
      reqReady = (({1'b0, count} + (cntW + 1)'(1)) < (cntW + 1)'(respDepth));
  end

  assign io.req_ready = reqReady;

  // Issue FSM: latch request, hold it on the divider port until taken, wait for result.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state               <= IDLE;
      io.div_inValid      <= 1'b0;
      io.div_sqrtOp       <= 1'b0;
      io.div_a            <= '0;
      io.div_b            <= '0;
      io.div_roundingMode <= '0;
      heldTag             <= '0;
      io.protoErr         <= 1'b0;
    end else begin
      if (io.div_outValid && (state != BUSY))
        io.protoErr <= 1'b1;
      if (busyDone && (io.div_sqrtOpOut != io.div_sqrtOp))
        io.protoErr <= 1'b1;

      if (accept) begin
        io.div_sqrtOp       <= io.req_sqrtOp;
        io.div_a            <= io.req_a;
        io.div_b            <= io.req_b;
        io.div_roundingMode <= io.req_roundingMode;
        heldTag             <= io.req_tag;
        io.div_inValid      <= 1'b1;
        state               <= ISSUE;
      end else begin
        case (state)
          ISSUE: if (io.div_inReady) begin
            io.div_inValid <= 1'b0;
            state          <= BUSY;
          end
          BUSY: if (io.div_outValid) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Response FIFO: capture divider results with their tag, release in order.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      count <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      for (int i = 0; i < respDepth; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wrPtr] <= {io.div_sqrtOpOut, io.div_out, io.div_exceptionFlags, heldTag};
        wrPtr      <= nextPtr(wrPtr);
      end
      if (pop) rdPtr <= nextPtr(rdPtr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign io.resp_valid = (count != '0);
  assign {io.resp_sqrtOp, io.resp_out, io.resp_exceptionFlags, io.resp_tag} = mem[rdPtr];
endmodule
